output_l_ctrl: RTL

- Parametrised successor to the fixed 10-LED output tap.
- Selects an OUT_W-bit field from an IN_W-bit result word at a run-time bit offset and latches it through a valid/ready load.
- Drives the field onto the board LEDs in one of four display modes: pass, blink, scroll or clear.
- Sits between the datapath result bus and the LED pins.

---
 rtl/output_l_ctrl_if.sv | 26 ++
 rtl/output_l_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/output_l_ctrl_if.sv
// Load/display bus for the LED output tap: the requester (master) drives the
// load request and watches the LED, mode and tick outputs of the tap (slave).
interface output_l_ctrl_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 10,
  parameter int OFS_W = 5
);
  logic [IN_W-1:0]  inNum;
  logic             ld_valid;
  logic             ld_ready;
  logic [OFS_W-1:0] ld_ofs;
  logic [1:0]       ld_mode;
  logic [OUT_W-1:0] outdt;
  logic [1:0]       mode_o;
  logic             tick_o;

  modport master (
    output inNum, ld_valid, ld_ofs, ld_mode,
    input  ld_ready, outdt, mode_o, tick_o
  );

  modport slave (
    input  inNum, ld_valid, ld_ofs, ld_mode,
    output ld_ready, outdt, mode_o, tick_o
  );
endinterface

// File: rtl/output_l_ctrl.sv
// LED output tap: latches an OUT_W-bit field of inNum and shows it in PASS, BLINK,
// SCROLL or CLEAR mode. Define OUTPUT_L_ACTIVE_LOW_EN for inverted (common-anode) pins.
module output_l_ctrl #(
  parameter int IN_W      = 32,
  parameter int OUT_W     = 10,
  parameter int OFS_W     = 5,
  parameter int BLINK_DIV = 25000000
) (
  input  logic              clock,
  input  logic              resetn,
  output_l_ctrl_if.slave    bus
);

  localparam int CNT_W = $clog2(BLINK_DIV);

`ifdef OUTPUT_L_ACTIVE_LOW_EN
  localparam logic [OUT_W-1:0] POL_MASK = {OUT_W{1'b1}};
`else
  localparam logic [OUT_W-1:0] POL_MASK = {OUT_W{1'b0}};
`endif

  typedef enum logic [1:0] {
    M_PASS   = 2'd0,
    M_BLINK  = 2'd1,
    M_SCROLL = 2'd2,
    M_CLEAR  = 2'd3
  } mode_e;

  mode_e            mode_q, mode_d;
  logic [OUT_W-1:0] field_q, field_d;
  logic [OUT_W-1:0] pin_q, pin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             tick_q, tick_d;
  logic             ready_q, ready_d;

  logic [IN_W-1:0]  shifted_s;
  logic [OUT_W-1:0] field_s;
  logic [OUT_W-1:0] rot_s;
  logic [OUT_W-1:0] on_s;
  logic             accept_s;
  logic             wrap_s;

  // Right shift zero-fills, so offsets reaching past the word yield zero bits.
  assign shifted_s = bus.inNum >> bus.ld_ofs;
  assign field_s   = shifted_s[OUT_W-1:0];

  // The pin register holds the already-polarised value; rotation commutes with inversion.
  assign rot_s    = (pin_q << 1) | (pin_q >> (OUT_W - 1));
  assign on_s     = field_q ^ POL_MASK;
  assign accept_s = bus.ld_valid & ready_q;
  assign wrap_s   = (cnt_q == CNT_W'(BLINK_DIV - 1));

  // Next-state logic: a load always wins over a coincident display tick.
  always_comb begin
    mode_d  = mode_q;
    field_d = field_q;
    pin_d   = pin_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    tick_d  = 1'b0;
    ready_d = 1'b1;
    if (accept_s) begin
      ready_d = 1'b0;
      mode_d  = mode_e'(bus.ld_mode);
      field_d = field_s;
      cnt_d   = {CNT_W{1'b0}};
      phase_d = 1'b0;
      case (mode_e'(bus.ld_mode))
        M_CLEAR: pin_d = POL_MASK;
        default: pin_d = field_s ^ POL_MASK;
      endcase
    end else begin
      case (mode_q)
        M_BLINK: begin
          if (wrap_s) begin
            cnt_d   = {CNT_W{1'b0}};
            tick_d  = 1'b1;
            phase_d = ~phase_q;
            pin_d   = phase_q ? on_s : POL_MASK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        M_SCROLL: begin
          if (wrap_s) begin
            cnt_d  = {CNT_W{1'b0}};
            tick_d = 1'b1;
            pin_d  = rot_s;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        M_PASS:  cnt_d = {CNT_W{1'b0}};
        M_CLEAR: cnt_d = {CNT_W{1'b0}};
        default: cnt_d = {CNT_W{1'b0}};
      endcase
    end
  end

  // State register; asynchronous reset returns the tap to idle PASS with dark LEDs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mode_q  <= M_PASS;
      field_q <= {OUT_W{1'b0}};
      pin_q   <= POL_MASK;
      cnt_q   <= {CNT_W{1'b0}};
      phase_q <= 1'b0;
      tick_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      field_q <= field_d;
      pin_q   <= pin_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      tick_q  <= tick_d;
      ready_q <= ready_d;
    end
  end

  assign bus.outdt    = pin_q;
  assign bus.mode_o   = mode_q;
  assign bus.tick_o   = tick_q;
  assign bus.ld_ready = ready_q;

endmodule
